mips_fetch_queue: RTL and testbench
===================================

MIPS_FETCH_QUEUE -- requirements
Module: mips_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word address of the request (PC, word-indexed).
REQ-007 imem_ack  input  1  memory completes the request on this edge.
REQ-008 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-009 redirect  input  1  taken branch; flush the queue and refetch.
REQ-010 redirect_pc  input  32  branch target word address.
REQ-011 halt  input  1  level; stops new fetch requests while high.
REQ-012 id_valid  output  1  head entry available to the ID stage.
REQ-013 id_ready  input  1  ID stage accepts the head entry.
REQ-014 id_ir  output  32  head instruction word.
REQ-015 id_npc  output  32  head entry's fetch address + 1.
REQ-016 count  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-017 Fetch FSM SHALL have states IDLE, WAIT, DROP, with fetch_pc as the next fetch address.
REQ-018 IDLE->WAIT SHALL occur on an edge with halt=0, redirect=0 and count_next < DEPTH; that edge SHALL drive imem_req=1 and imem_addr=fetch_pc as registered outputs.
REQ-019 In WAIT and DROP, imem_req SHALL stay 1 and imem_addr SHALL stay stable until an edge with imem_ack=1.
REQ-020 A transfer SHALL complete on any edge where imem_req=1 and imem_ack=1.
REQ-021 At most one request SHALL be outstanding.
REQ-022 A WAIT completion without redirect SHALL push {imem_rdata, imem_addr+1} into the queue and set fetch_pc=imem_addr+1.
REQ-023 A WAIT completion SHALL go to WAIT at the next address if the issue conditions still hold, otherwise to IDLE; back-to-back fetches SHALL complete at 1 word/cycle when ack is held high.
REQ-024 A push SHALL only be issued when space exists: count plus outstanding requests SHALL never exceed DEPTH.
REQ-025 id_valid SHALL equal (count != 0).
REQ-026 id_ir and id_npc SHALL present the head entry.
REQ-027 A pop SHALL occur on an edge with id_valid=1 and id_ready=1.
REQ-028 Simultaneous push and pop SHALL leave count unchanged.
REQ-029 Fetch latency SHALL be as follows: data acked at edge N SHALL be visible at the queue outputs after edge N (id_valid=1 from N to N+1); there SHALL be no combinational bypass.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 fetch_pc and npc SHALL wrap 32'hFFFFFFFF -> 0.
REQ-032 On an edge with redirect=1, count, rd_ptr and wr_ptr SHALL be cleared to 0 and fetch_pc SHALL be loaded with redirect_pc.
REQ-033 On a redirect edge, any same-edge pop or push SHALL be discarded; flush wins.
REQ-034 On a redirect while in WAIT with no ack on that edge, the FSM SHALL go to DROP.
REQ-035 In DROP, the returning word SHALL be discarded on ack, then the FSM SHALL go to IDLE; the new fetch SHALL issue on a later edge per REQ-018.
REQ-036 On a redirect coinciding with ack, the acked data SHALL be discarded and the FSM SHALL go to IDLE.
REQ-037 On a redirect in DROP, fetch_pc SHALL be updated and the FSM SHALL remain in DROP.
REQ-038 halt=1 SHALL block new requests only: an outstanding request SHALL complete and push normally, and the queue SHALL continue to drain.
REQ-039 When halt falls, fetching SHALL resume from fetch_pc.
REQ-040 Redirect SHALL remain effective while halt=1.

Reset
REQ-041 While rst_n=0, the block SHALL hold: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_ir=0, id_npc=0, count=0, state IDLE, fetch_pc=RESET_PC, pointers=0.
REQ-042 Reset asserted mid-transaction SHALL drop imem_req immediately (asynchronously) and abandon the request; an ack arriving during reset SHALL be ignored.
REQ-043 The first request SHALL issue on the first edge after rst_n rises, with addr=RESET_PC.

Verification
REQ-044 Memory acks every cycle with rdata=addr+32'h100, id_ready=1 -> id_ir sequence 0x100, 0x101, 0x102..., id_npc=1, 2, 3..., one per cycle after the first.
REQ-045 id_ready=0, ack always 1, DEPTH=4 -> exactly 4 pushes; count=4; imem_req=0 thereafter; set id_ready=1 -> fetching resumes at addr 4.
REQ-046 Request to addr 5 outstanding, redirect with redirect_pc=0x20, ack delayed 3 cycles -> DROP entered, word from 5 discarded, next imem_addr=0x20, first id_npc=0x21, count=0 immediately after the redirect edge.
REQ-047 redirect on the same edge as ack and pop with count=2 -> count=0, the acked word is never presented, and the next request is addr=redirect_pc.
REQ-048 halt=1 while a request is outstanding -> that word is pushed and no further imem_req occurs; halt=0 -> the request resumes at the next sequential address.
REQ-049 rst_n pulsed low during WAIT -> imem_req=0 within the reset, all outputs at reset values, and the first post-reset addr=RESET_PC.

Source files
------------

// File: rtl/mips_fetch_queue.sv
// Instruction fetch unit with a small in-order queue feeding the ID stage.
// One outstanding memory request at a time; redirects flush the queue and squash in-flight data.
module mips_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_ir,
  output logic [31:0]                id_npc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d, count_nx;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]     mem_ir_q  [DEPTH];
  logic [31:0]     mem_npc_q [DEPTH];
  logic            push, pop, issue_ok;

  always_comb begin
    push     = (state_q == StWait) && imem_ack && !redirect;
    pop      = (count_q != '0) && id_ready && !redirect;
    count_nx = count_q + CW'(push) - CW'(pop);
    // Issue only if the queue will still have room for the word being requested.
    issue_ok = !halt && !redirect && (count_nx < CW'(DEPTH));

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    count_d    = count_nx;
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);

    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
    end

    case (state_q)
      StIdle: begin
        if (issue_ok) begin
          state_d = StWait;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      StWait: begin
        if (imem_ack) begin
          if (!redirect) fetch_pc_d = addr_q + 32'd1;
          if (issue_ok) begin
            addr_d = addr_q + 32'd1;
          end else begin
            state_d = StIdle;
            req_d   = 1'b0;
          end
        end else if (redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        // Stale word returns here and is thrown away.
        if (imem_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ir_q[wr_ptr_q]  <= imem_rdata;
      mem_npc_q[wr_ptr_q] <= addr_q + 32'd1;
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  always_comb begin
    imem_req  = req_q;
    imem_addr = addr_q;
    count     = count_q;
    id_valid  = (count_q != '0);
    id_ir     = id_valid ? mem_ir_q[rd_ptr_q]  : 32'h0;
    id_npc    = id_valid ? mem_npc_q[rd_ptr_q] : 32'h0;
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue: streaming, back-pressure, redirect/drop, halt,
// mid-transaction reset and PC wrap.
module tb_mips_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_npc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  mips_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ir       (id_ir),
    .id_npc      (id_npc),
    .count       (count)
  );

  // Memory returns addr + 0x100 for every word.
  assign imem_rdata = imem_addr + 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    halt = 1'b0; id_ready = 1'b0;
    #3;
    chk("rst_req",    32'(imem_req), 32'h0);
    chk("rst_addr",   imem_addr,     32'h0);
    chk("rst_valid",  32'(id_valid), 32'h0);
    chk("rst_ir",     id_ir,         32'h0);
    chk("rst_npc",    id_npc,        32'h0);
    chk("rst_count",  32'(count),    32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Streaming: ack every cycle, ID always ready.
    imem_ack = 1'b1; id_ready = 1'b1;
    tick();  // edge 1
    chk("e1_req",   32'(imem_req), 32'h1);
    chk("e1_addr",  imem_addr,     32'h0);
    chk("e1_valid", 32'(id_valid), 32'h0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("str_ir",    id_ir,      32'h100 + 32'(k - 2));
      chk("str_npc",   id_npc,     32'(k - 1));
      chk("str_addr",  imem_addr,  32'(k - 1));
      chk("str_count", 32'(count), 32'h1);
    end

    // Back-pressure: queue fills to DEPTH and fetch stops.
    id_ready = 1'b0;
    tick(); tick(); tick();  // edges 7..9
    chk("full_count", 32'(count),    32'h4);
    chk("full_req",   32'(imem_req), 32'h0);
    chk("full_ir",    id_ir,         32'h104);
    tick(); tick();
    chk("full_req2",   32'(imem_req), 32'h0);
    chk("full_count2", 32'(count),    32'h4);
    id_ready = 1'b1;
    tick();  // edge 12
    chk("resume_req",   32'(imem_req), 32'h1);
    chk("resume_addr",  imem_addr,     32'h8);
    chk("resume_count", 32'(count),    32'h3);
    chk("resume_ir",    id_ir,         32'h105);
    chk("resume_npc",   id_npc,        32'h6);

    // Redirect with the request outstanding, ack delayed.
    imem_ack = 1'b0;
    tick();  // edge 13
    chk("drain_count", 32'(count), 32'h2);
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();  // edge 14
    redirect = 1'b0;
    chk("rd_count", 32'(count),    32'h0);
    chk("rd_valid", 32'(id_valid), 32'h0);
    chk("rd_req",   32'(imem_req), 32'h1);
    chk("rd_addr",  imem_addr,     32'h8);
    tick(); tick();
    chk("drop_req",  32'(imem_req), 32'h1);
    chk("drop_addr", imem_addr,     32'h8);
    imem_ack = 1'b1;
    tick();  // edge 17
    chk("drop_done_req",   32'(imem_req), 32'h0);
    chk("drop_done_count", 32'(count),    32'h0);
    tick();  // edge 18
    chk("rd_new_req",  32'(imem_req), 32'h1);
    chk("rd_new_addr", imem_addr,     32'h20);
    tick();  // edge 19
    chk("rd_first_ir",  id_ir,  32'h120);
    chk("rd_first_npc", id_npc, 32'h21);
    chk("rd_first_cnt", 32'(count), 32'h1);

    // Redirect coinciding with ack and pop, count=2.
    id_ready = 1'b0;
    tick();  // edge 20
    chk("pre_flush_count", 32'(count), 32'h2);
    redirect = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
    tick();  // edge 21
    redirect = 1'b0;
    chk("flush_count", 32'(count),    32'h0);
    chk("flush_valid", 32'(id_valid), 32'h0);
    chk("flush_req",   32'(imem_req), 32'h0);
    tick();  // edge 22
    chk("flush_new_addr",  imem_addr,     32'h40);
    chk("flush_new_valid", 32'(id_valid), 32'h0);
    tick();  // edge 23
    chk("flush_first_ir", id_ir, 32'h140);

    // Halt while a request is outstanding.
    imem_ack = 1'b0; halt = 1'b1;
    tick();  // edge 24
    chk("halt_wait_req", 32'(imem_req), 32'h1);
    chk("halt_wait_cnt", 32'(count),    32'h0);
    imem_ack = 1'b1;
    tick();  // edge 25
    chk("halt_push_ir",  id_ir,         32'h141);
    chk("halt_push_req", 32'(imem_req), 32'h0);
    tick(); tick();
    chk("halt_idle_req", 32'(imem_req), 32'h0);
    chk("halt_idle_cnt", 32'(count),    32'h0);
    halt = 1'b0;
    tick();  // edge 28
    chk("unhalt_req",  32'(imem_req), 32'h1);
    chk("unhalt_addr", imem_addr,     32'h42);

    // Asynchronous reset during WAIT, with ack arriving inside reset.
    imem_ack = 1'b0; id_ready = 1'b0;
    tick();
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req), 32'h0);
    chk("arst_addr",  imem_addr,     32'h0);
    chk("arst_count", 32'(count),    32'h0);
    chk("arst_valid", 32'(id_valid), 32'h0);
    imem_ack = 1'b1;
    tick(); tick();
    chk("arst_hold_req",   32'(imem_req), 32'h0);
    chk("arst_hold_count", 32'(count),    32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req",  32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr,     32'h0);
    tick();
    chk("post_rst_ir",  id_ir,  32'h100);
    chk("post_rst_npc", id_npc, 32'h1);

    // PC wrap at 0xFFFFFFFF.
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0; imem_ack = 1'b1;
    tick();
    chk("wrap_drop_req", 32'(imem_req), 32'h0);
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_ir",    id_ir,      32'h0000_00FF);
    chk("wrap_npc",   id_npc,     32'h0);
    chk("wrap_next",  imem_addr,  32'h0);
    chk("wrap_count", 32'(count), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
